mips_fetch: RTL

Instruction-fetch front end for the `MIPS` core, directly upstream of decode. It owns the program counter and issues single-outstanding requests to instruction memory over a request/acknowledge/response handshake. It delivers each fetched word with its PC into the IF/ID register and handles decode stalls with a one-entry skid buffer. It applies branch/jump redirects by discarding wrong-path responses.

---
 rtl/mips_fetch.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/mips_fetch.sv
// Instruction-fetch front end: owns the PC, keeps one imem request in flight,
// feeds the IF/ID register through a one-entry skid buffer and drops wrong-path responses.
module mips_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic [1:0]  dbg_state
);

  // Handshake: a request transfers in any cycle where imem_req && imem_ack;
  // imem_addr stays stable until then, and exactly one imem_rvalid answers it later.
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    DROP  = 2'd2
  } state_e;

  localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & 32'hFFFF_FFFC;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic [31:0] id_pc_q, id_pc_d;

  logic        accept;
  logic        resp_in;
  logic [31:0] redirect_target;

  // Request is a pure decode of registered state; rst only masks it.
  assign imem_req        = (state_q == FETCH) && !buf_valid_q && !rst;
  assign imem_addr       = pc_q;
  assign accept          = imem_req && imem_ack;
  assign resp_in         = (state_q == WAIT) && imem_rvalid;
  assign redirect_target = redirect_pc & 32'hFFFF_FFFC;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_pc_d    = req_pc_q;
    buf_valid_d = buf_valid_q;
    buf_instr_d = buf_instr_q;
    buf_pc_d    = buf_pc_q;
    id_valid_d  = id_valid_q;
    id_instr_d  = id_instr_q;
    id_pc_d     = id_pc_q;

    case (state_q)
      FETCH: begin
        if (accept) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + 32'd4;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          state_d = FETCH;
          if (!id_valid_q || !stall) begin
            id_valid_d = 1'b1;
            id_instr_d = imem_rdata;
            id_pc_d    = req_pc_q;
          end else begin
            buf_valid_d = 1'b1;
            buf_instr_d = imem_rdata;
            buf_pc_d    = req_pc_q;
          end
        end
      end
      DROP: begin
        if (imem_rvalid) state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase

    // Decode consumed IF/ID: refill from the skid buffer or go empty.
    if (!resp_in && !stall) begin
      if (buf_valid_q) begin
        id_valid_d  = 1'b1;
        id_instr_d  = buf_instr_q;
        id_pc_d     = buf_pc_q;
        buf_valid_d = 1'b0;
      end else begin
        id_valid_d = 1'b0;
      end
    end

    if (redirect) begin
      pc_d        = redirect_target;
      id_valid_d  = 1'b0;
      id_instr_d  = 32'h0000_0000;
      buf_valid_d = 1'b0;
      case (state_q)
        FETCH:   state_d = accept ? DROP : FETCH;
        WAIT:    state_d = imem_rvalid ? FETCH : DROP;
        DROP:    state_d = imem_rvalid ? FETCH : DROP;
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC_ALIGNED;
      req_pc_q    <= 32'h0000_0000;
      buf_valid_q <= 1'b0;
      buf_instr_q <= 32'h0000_0000;
      buf_pc_q    <= 32'h0000_0000;
      id_valid_q  <= 1'b0;
      id_instr_q  <= 32'h0000_0000;
      id_pc_q     <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_pc_q    <= req_pc_d;
      buf_valid_q <= buf_valid_d;
      buf_instr_q <= buf_instr_d;
      buf_pc_q    <= buf_pc_d;
      id_valid_q  <= id_valid_d;
      id_instr_q  <= id_instr_d;
      id_pc_q     <= id_pc_d;
    end
  end

  assign id_valid    = id_valid_q;
  assign id_instr    = id_instr_q;
  assign id_pc       = id_pc_q;
  assign id_pc_plus4 = id_pc_q + 32'd4;
  assign dbg_state   = state_q;

endmodule
